// File: rtl/program_memory.sv
// program_memory: instruction store with a streaming loader port and a
// one-cycle registered fetch port. The loader walks its own write address
// (base + count, wrapping modulo DEPTH), handshakes each word and keeps a
// running checksum. Fetches are dropped while a load session is active.
module program_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [DATA_W-1:0] load_csum,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_csum;
  logic              r_load_ready;
  logic              r_load_busy;
  logic              r_load_done;
  logic              r_load_err;
  logic [DATA_W-1:0] r_fetch_data;
  logic              r_fetch_valid;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_last;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_csum_next;

  // A word moves only in LOAD; the write address wraps naturally at ADDR_W bits.
  assign w_accept    = (r_state == S_LOAD) && load_valid;
  assign w_last      = (r_count == (r_len - ONE));
  assign w_waddr     = r_base + r_count[ADDR_W-1:0];
  assign w_csum_next = r_csum + load_data;

  // Session window captured with an accepted-or-not start; no reset needed,
  // the values are only consulted after the FSM has left IDLE.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && load_start) begin
      r_base <= load_base;
      r_len  <= load_len;
    end
  end

  // Loader FSM: IDLE -> LOAD -> DONE -> IDLE, with all handshake flags registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_csum       <= '0;
      r_load_ready <= 1'b0;
      r_load_busy  <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            if (load_len > LEN_MAX) begin
              // Rejected request: checksum of the previous session survives.
              r_load_err <= 1'b1;
            end else if (load_len == '0) begin
              // Empty session: nothing written, but it still completes.
              r_count     <= '0;
              r_csum      <= '0;
              r_load_done <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_count      <= '0;
              r_csum       <= '0;
              r_load_ready <= 1'b1;
              r_load_busy  <= 1'b1;
              r_state      <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_count <= r_count + ONE;
            r_csum  <= w_csum_next;
            if (w_last) begin
              r_load_ready <= 1'b0;
              r_load_busy  <= 1'b0;
              r_load_done  <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_load_ready <= 1'b0;
          r_load_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[w_waddr] <= load_data;
    end
  end

  // Fetch port: one-cycle read, dropped while a session is loading; data holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_data  <= '0;
      r_fetch_valid <= 1'b0;
    end else if (fetch_en && !r_load_busy) begin
      r_fetch_data  <= r_mem[fetch_addr];
      r_fetch_valid <= 1'b1;
    end else begin
      r_fetch_valid <= 1'b0;
    end
  end

  assign load_ready  = r_load_ready;
  assign load_busy   = r_load_busy;
  assign load_done   = r_load_done;
  assign load_err    = r_load_err;
  assign load_csum   = r_csum;
  assign fetch_data  = r_fetch_data;
  assign fetch_valid = r_fetch_valid;

endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory: directed stimulus with a scoreboard. Stimulus pushes
// expected fetch words, expected completion checksums and expected error
// pulses into queues; a negedge monitor pops and compares them.
module tb_program_memory;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic [ADDR_W-1:0] load_base = '0;
  logic [ADDR_W:0]   load_len = '0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [DATA_W-1:0] load_csum;
  logic              fetch_en = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;

  always #5 clk = ~clk;

  program_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .load_csum  (load_csum),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid)
  );

  typedef struct {
    logic [7:0] d;
    bit         chk;
  } fexp_t;

  fexp_t      fq[$];
  logic [7:0] dq[$];
  logic [7:0] wq[$];
  int         err_exp = 0;
  int         checks  = 0;
  int         errors  = 0;
  logic [7:0] model [256];
  bit         known [256];
  fexp_t      mon_e;
  logic [7:0] mon_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch beat; expectation comes from the shadow model.
  task automatic fetch(input logic [7:0] a);
    fexp_t e;
    e.d = model[a];
    e.chk = known[a];
    fetch_en   = 1'b1;
    fetch_addr = a;
    fq.push_back(e);
    step();
  endtask

  // Full load session of the words in wq; optional one-cycle gap before word 1.
  task automatic load_seq(input logic [7:0] b, input bit gap);
    logic [7:0] cs;
    logic [7:0] a;
    int n;
    n  = wq.size();
    cs = 8'h00;
    for (int i = 0; i < n; i++) cs = cs + wq[i];
    dq.push_back(cs);
    load_start = 1'b1;
    load_base  = b;
    load_len   = 9'(n);
    step();
    load_start = 1'b0;
    chk("busy_after_start", 32'(load_busy), 32'd1);
    chk("ready_after_start", 32'(load_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (gap && i == 1) begin
        load_valid = 1'b0;
        step();
        chk("ready_in_gap", 32'(load_ready), 32'd1);
      end
      load_valid = 1'b1;
      load_data  = wq[i];
      a = b + 8'(i);
      model[a] = wq[i];
      known[a] = 1'b1;
      step();
    end
    load_valid = 1'b0;
    chk("busy_after_last", 32'(load_busy), 32'd0);
    step();
    chk("csum_hold", 32'(load_csum), 32'(cs));
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (fetch_valid) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected: got valid data 0x%0h expected no fetch_valid", fetch_data);
        end else begin
          mon_e = fq.pop_front();
          if (mon_e.chk) chk("fetch_data", 32'(fetch_data), 32'(mon_e.d));
        end
      end
      if (load_done) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got load_done=1 expected 0");
        end else begin
          mon_c = dq.pop_front();
          chk("done_csum", 32'(load_csum), 32'(mon_c));
        end
      end
      if (load_err) begin
        checks++;
        if (err_exp == 0) begin
          errors++;
          $display("FAIL err_unexpected: got load_err=1 expected 0");
        end else begin
          err_exp--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      model[i] = 8'h00;
      known[i] = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_busy", 32'(load_busy), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_csum", 32'(load_csum), 32'd0);
    chk("rst_fdata", 32'(fetch_data), 32'd0);
    chk("rst_fvalid", 32'(fetch_valid), 32'd0);
    reset = 1'b0;
    step();

    // First fetch after reset: one-cycle latency, contents undefined
    fetch(8'h00);
    fetch_en = 1'b0;
    chk("fetch_latency", 32'(fetch_valid), 32'd1);
    step();
    chk("fetch_valid_drop", 32'(fetch_valid), 32'd0);

    // Base 0x10, four words with a valid gap; checksum 0x0A
    wq = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_seq(8'h10, 1'b1);
    chk("csum_0A", 32'(load_csum), 32'h0A);
    fetch(8'h10);
    fetch(8'h11);
    fetch(8'h12);
    fetch(8'h13);
    fetch_en = 1'b0;
    step();

    // Address wrap: FE, FF, 00; checksum AA+BB+CC = 0x231 -> 0x31
    wq = '{8'hAA, 8'hBB, 8'hCC};
    load_seq(8'hFE, 1'b0);
    chk("csum_31", 32'(load_csum), 32'h31);
    fetch(8'hFE);
    fetch(8'hFF);
    fetch(8'h00);
    fetch_en = 1'b0;
    step();

    // Oversized length is rejected; checksum untouched
    err_exp++;
    load_start = 1'b1;
    load_base  = 8'h20;
    load_len   = 9'h101;
    step();
    load_start = 1'b0;
    chk("err_stays_idle", 32'(load_busy), 32'd0);
    step();
    chk("err_csum_kept", 32'(load_csum), 32'h31);

    // Zero length completes next cycle with checksum cleared, no writes
    dq.push_back(8'h00);
    load_start = 1'b1;
    load_base  = 8'h10;
    load_len   = 9'h000;
    step();
    load_start = 1'b0;
    chk("len0_not_busy", 32'(load_busy), 32'd0);
    step();
    chk("len0_csum", 32'(load_csum), 32'h00);
    fetch(8'h10);
    fetch_en = 1'b0;
    step();

    // Fetch and restart attempt during LOAD are both ignored
    dq.push_back(8'h61);
    load_start = 1'b1;
    load_base  = 8'h40;
    load_len   = 9'd2;
    step();
    fetch_en   = 1'b1;
    fetch_addr = 8'h10;
    load_base  = 8'h80;
    load_len   = 9'd5;
    step();
    fetch_en   = 1'b0;
    load_start = 1'b0;
    chk("fetch_blocked", 32'(fetch_valid), 32'd0);
    chk("busy_restart_ignored", 32'(load_busy), 32'd1);
    load_valid = 1'b1;
    load_data  = 8'h30;
    model[8'h40] = 8'h30;
    known[8'h40] = 1'b1;
    step();
    load_data  = 8'h31;
    model[8'h41] = 8'h31;
    known[8'h41] = 1'b1;
    step();
    load_valid = 1'b0;
    chk("busy_done_after_2", 32'(load_busy), 32'd0);
    step();
    fetch(8'h40);
    fetch(8'h41);
    fetch_en = 1'b0;
    step();

    // Reset after 2 of 5 words: two new words land, the rest keep old data
    wq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    load_seq(8'h60, 1'b0);
    load_start = 1'b1;
    load_base  = 8'h60;
    load_len   = 9'd5;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'h21;
    model[8'h60] = 8'h21;
    step();
    load_data  = 8'h22;
    model[8'h61] = 8'h22;
    step();
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(load_busy), 32'd0);
    chk("abort_ready", 32'(load_ready), 32'd0);
    chk("abort_csum", 32'(load_csum), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    fetch(8'h60);
    fetch(8'h61);
    fetch(8'h62);
    fetch(8'h63);
    fetch(8'h64);
    fetch_en = 1'b0;
    repeat (3) step();

    chk("fetch_queue_empty", 32'(fq.size()), 32'd0);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    chk("err_pending", 32'(err_exp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
